lsu_mem_ctrl: RTL and testbench

Load/store controller between the pipeline MEM stage and `DMem`. It accepts one memory request at a time over a valid/ready handshake and checks alignment. Requests in the MMIO window are decoded locally (LED register, switch input). All other requests are sequenced into `DMem`, which samples its address on the falling edge and registers its read data, so a multi-cycle hold is needed. Completion is returned as a one-cycle response pulse while the pipeline stalls on `req_ready`.

---
 rtl/lsu_mem_ctrl_if.sv | 22 ++
 rtl/lsu_mem_ctrl.sv | 118 +++++++++++
 tb/tb_lsu_mem_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline-side request/response bundle of the load/store controller.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one request at a time into DMem or the local MMIO window.
// Latency err/MMIO 1, store DMEM_LAT+1, load DMEM_LAT+2 cycles; req_ready is low while busy.
module lsu_mem_ctrl #(
    parameter int          DMEM_LAT  = 2,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FC00,
    parameter logic [31:0] LED_ADDR  = 32'hFFFF_FC60,
    parameter logic [31:0] SW_ADDR   = 32'hFFFF_FC70
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_mem_ctrl_if.slave      bus,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [1:0]         load_type,
    output logic [31:0]        addr,
    output logic [31:0]        din,
    input  logic [31:0]        dout,
    input  logic [15:0]        sw_in,
    output logic [15:0]        led_out
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    localparam int CW = (DMEM_LAT > 2) ? $clog2(DMEM_LAT) : 1;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic [15:0]   sw_meta;
    logic [15:0]   sw_sync;
    logic          misaligned;
    logic          in_mmio;

    always_comb begin
        misaligned = (bus.req_size == 2'b11) ||
                     ((bus.req_size == 2'b00) && (bus.req_addr[1:0] != 2'b00)) ||
                     ((bus.req_size == 2'b01) && bus.req_addr[0]);
        in_mmio    = (bus.req_addr[31:10] == MMIO_BASE[31:10]);
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign MemRead        = ((state == ACCESS) && !we_q) || (state == CAPTURE);
    assign MemWrite       = (state == ACCESS) && we_q;
    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_err   = resp_err;
    assign bus.resp_rdata = resp_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            load_type  <= 2'd0;
            addr       <= 32'd0;
            din        <= 32'd0;
            led_out    <= 16'd0;
            sw_meta    <= 16'd0;
            sw_sync    <= 16'd0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q <= bus.req_we;
                        if (misaligned) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                            state      <= RESP;
                        end else if (in_mmio) begin
                            resp_err   <= 1'b0;
                            resp_rdata <= (!bus.req_we && (bus.req_addr == SW_ADDR)) ?
                                          {16'd0, sw_sync} : 32'd0;
                            if (bus.req_we && (bus.req_addr == LED_ADDR))
                                led_out <= bus.req_wdata[15:0];
                            state <= RESP;
                        end else begin
                            addr      <= bus.req_addr;
                            din       <= bus.req_wdata;
                            load_type <= bus.req_size;
                            cnt       <= CW'(DMEM_LAT - 1);
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (we_q) begin
                            resp_err   <= 1'b0;
                            resp_rdata <= 32'd0;
                            state      <= RESP;
                        end else begin
                            state <= CAPTURE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    // DMem registered its read data on a falling edge inside ACCESS.
                    resp_err   <= 1'b0;
                    resp_rdata <= dout;
                    state      <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead, MemWrite;
    logic [1:0]  load_type;
    logic [31:0] addr, din;
    logic [31:0] dout = 32'd0;
    logic [15:0] sw_in = 16'd0;
    logic [15:0] led_out;

    lsu_mem_ctrl_if bus();

    lsu_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .MemRead(MemRead), .MemWrite(MemWrite), .load_type(load_type),
        .addr(addr), .din(din), .dout(dout),
        .sw_in(sw_in), .led_out(led_out)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DMem model: little-endian bytes, sampled on the falling edge, sign-extended registered read.
    logic [7:0] mem [0:1023];
    always @(negedge clk) begin
        if (MemWrite) begin
            case (load_type)
                2'b00: begin
                    mem[addr[9:0]]          <= din[7:0];
                    mem[addr[9:0] + 10'd1]  <= din[15:8];
                    mem[addr[9:0] + 10'd2]  <= din[23:16];
                    mem[addr[9:0] + 10'd3]  <= din[31:24];
                end
                2'b01: begin
                    mem[addr[9:0]]          <= din[7:0];
                    mem[addr[9:0] + 10'd1]  <= din[15:8];
                end
                2'b10: mem[addr[9:0]] <= din[7:0];
                default: ;
            endcase
        end
        if (MemRead) begin
            case (load_type)
                2'b00: dout <= {mem[addr[9:0] + 10'd3], mem[addr[9:0] + 10'd2],
                                mem[addr[9:0] + 10'd1], mem[addr[9:0]]};
                2'b01: dout <= {{16{mem[addr[9:0] + 10'd1][7]}}, mem[addr[9:0] + 10'd1], mem[addr[9:0]]};
                2'b10: dout <= {{24{mem[addr[9:0]][7]}}, mem[addr[9:0]]};
                default: dout <= 32'd0;
            endcase
        end
    end

    int          r_lat, r_wr, r_rd, r_acc;
    logic [31:0] r_rdata;
    logic        r_err;

    // Issue one request, wait for its response (bounded), record latency and strobe counts.
    task automatic do_req(input logic we, input logic [1:0] size,
                          input logic [31:0] a, input logic [31:0] wd);
        int w;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk);
        r_acc = cyc;
        #1;
        bus.req_valid = 1'b0;
        r_lat = 0; r_wr = 0; r_rd = 0; r_rdata = 32'hX; r_err = 1'bX;
        for (int i = 1; i <= 20; i++) begin
            if (MemWrite) r_wr++;
            if (MemRead)  r_rd++;
            if (bus.resp_valid) begin
                r_lat   = i;
                r_rdata = bus.resp_rdata;
                r_err   = bus.resp_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int spurious = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'($urandom);
            bus.req_we    = 1'($urandom);
            bus.req_size  = 2'($urandom);
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            sw_in         = 16'($urandom);
            @(posedge clk); #1;
        end
        tot_cnt++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err} !== 3'b100)
            $display("FAIL reset_hs: got rdy/vld/err=%b want 100", {bus.req_ready, bus.resp_valid, bus.resp_err});
        else pass_cnt++;
        tot_cnt++;
        if ({MemRead, MemWrite, load_type} !== 4'b0)
            $display("FAIL reset_strobes: got %b want 0000", {MemRead, MemWrite, load_type});
        else pass_cnt++;
        tot_cnt++;
        if ({bus.resp_rdata, addr, din, led_out} !== 112'd0)
            $display("FAIL reset_data: got rdata=%h addr=%h din=%h led=%h want all 0",
                     bus.resp_rdata, addr, din, led_out);
        else pass_cnt++;
        bus.req_valid = 1'b0;
        sw_in = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) spurious++;
        end
        tot_cnt++;
        if (spurious !== 0) $display("FAIL reset_release: got %0d resp pulses want 0", spurious);
        else pass_cnt++;
    endtask

    task automatic test_word();
        do_req(1'b1, 2'b00, 32'h100, 32'hDEADBEEF);
        tot_cnt++;
        if ({r_lat, r_wr, r_rd} !== {32'd3, 32'd2, 32'd0})
            $display("FAIL word_store: got lat=%0d wr=%0d rd=%0d want 3/2/0", r_lat, r_wr, r_rd);
        else pass_cnt++;
        do_req(1'b0, 2'b00, 32'h100, 32'h0);
        tot_cnt++;
        if (r_lat !== 4 || r_rdata !== 32'hDEADBEEF || r_err !== 1'b0)
            $display("FAIL word_load: got lat=%0d data=%h err=%b want 4/deadbeef/0", r_lat, r_rdata, r_err);
        else pass_cnt++;
    endtask

    task automatic test_subword();
        do_req(1'b1, 2'b10, 32'h103, 32'h0000_0080);
        tot_cnt++;
        if (r_lat !== 3 || r_err !== 1'b0)
            $display("FAIL byte_store: got lat=%0d err=%b want 3/0", r_lat, r_err);
        else pass_cnt++;
        do_req(1'b0, 2'b10, 32'h103, 32'h0);
        tot_cnt++;
        if (r_rdata !== 32'hFFFFFF80)
            $display("FAIL byte_load: got %h want ffffff80", r_rdata);
        else pass_cnt++;
        do_req(1'b0, 2'b01, 32'h102, 32'h0);
        tot_cnt++;
        if (r_rdata !== 32'hFFFF80AD)
            $display("FAIL half_load: got %h want ffff80ad", r_rdata);
        else pass_cnt++;
    endtask

    task automatic test_misalign();
        do_req(1'b0, 2'b00, 32'h102, 32'h0);
        tot_cnt++;
        if (r_lat !== 1 || r_err !== 1'b1 || r_rd + r_wr !== 0 || r_rdata !== 32'd0)
            $display("FAIL mis_word: got lat=%0d err=%b strobes=%0d data=%h want 1/1/0/0",
                     r_lat, r_err, r_rd + r_wr, r_rdata);
        else pass_cnt++;
        do_req(1'b1, 2'b01, 32'h101, 32'h0000_FFFF);
        tot_cnt++;
        if (r_lat !== 1 || r_err !== 1'b1 || r_rd + r_wr !== 0)
            $display("FAIL mis_half: got lat=%0d err=%b strobes=%0d want 1/1/0", r_lat, r_err, r_rd + r_wr);
        else pass_cnt++;
        do_req(1'b1, 2'b11, 32'h0, 32'h1111_1111);
        tot_cnt++;
        if (r_lat !== 1 || r_err !== 1'b1 || r_rd + r_wr !== 0)
            $display("FAIL bad_size: got lat=%0d err=%b strobes=%0d want 1/1/0", r_lat, r_err, r_rd + r_wr);
        else pass_cnt++;
        do_req(1'b0, 2'b00, 32'h100, 32'h0);
        tot_cnt++;
        if (r_rdata !== 32'h80ADBEEF || r_err !== 1'b0)
            $display("FAIL mis_mem_intact: got %h err=%b want 80adbeef/0", r_rdata, r_err);
        else pass_cnt++;
    endtask

    task automatic test_mmio();
        do_req(1'b1, 2'b00, 32'hFFFFFC60, 32'h1234A5A5);
        tot_cnt++;
        if (r_lat !== 1 || led_out !== 16'hA5A5 || r_err !== 1'b0 || r_rd + r_wr !== 0)
            $display("FAIL led_store: got lat=%0d led=%h err=%b strobes=%0d want 1/a5a5/0/0",
                     r_lat, led_out, r_err, r_rd + r_wr);
        else pass_cnt++;
        sw_in = 16'h00F0;
        repeat (3) @(posedge clk);
        #1;
        do_req(1'b0, 2'b00, 32'hFFFFFC70, 32'h0);
        tot_cnt++;
        if (r_lat !== 1 || r_rdata !== 32'h000000F0)
            $display("FAIL sw_load: got lat=%0d data=%h want 1/000000f0", r_lat, r_rdata);
        else pass_cnt++;
        do_req(1'b0, 2'b00, 32'hFFFFFC80, 32'h0);
        tot_cnt++;
        if (r_lat !== 1 || r_rdata !== 32'd0 || led_out !== 16'hA5A5)
            $display("FAIL mmio_other: got lat=%0d data=%h led=%h want 1/0/a5a5", r_lat, r_rdata, led_out);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int first_acc, nresp;
        do_req(1'b1, 2'b01, 32'h200, 32'h0000_1234);
        first_acc = r_acc;
        do_req(1'b0, 2'b01, 32'h200, 32'h0);
        tot_cnt++;
        if (r_acc - first_acc !== 4 || r_rdata !== 32'h00001234)
            $display("FAIL b2b: got spacing=%0d data=%h want 4/00001234", r_acc - first_acc, r_rdata);
        else pass_cnt++;
        // Requester keeps req_valid up until it sees the response.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h100;
        nresp = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) begin
                nresp++;
                bus.req_valid = 1'b0;
                r_rdata = bus.resp_rdata;
            end
        end
        tot_cnt++;
        if (nresp !== 1 || r_rdata !== 32'h80ADBEEF)
            $display("FAIL held_valid: got resp=%0d data=%h want 1/80adbeef", nresp, r_rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int nresp = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h100;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        tot_cnt++;
        if (MemRead !== 1'b1) $display("FAIL mid_access: got MemRead=%b want 1", MemRead);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        tot_cnt++;
        if ({MemRead, MemWrite, bus.resp_valid, bus.req_ready} !== 4'b0001)
            $display("FAIL mid_reset: got rd/wr/vld/rdy=%b want 0001",
                     {MemRead, MemWrite, bus.resp_valid, bus.req_ready});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) nresp++;
        end
        tot_cnt++;
        if (nresp !== 0) $display("FAIL mid_no_resp: got %0d pulses want 0", nresp);
        else pass_cnt++;
        do_req(1'b0, 2'b00, 32'h100, 32'h0);
        tot_cnt++;
        if (r_lat !== 4 || r_rdata !== 32'h80ADBEEF)
            $display("FAIL post_reset_load: got lat=%0d data=%h want 4/80adbeef", r_lat, r_rdata);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        test_reset();
        test_word();
        test_subword();
        test_misalign();
        test_mmio();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
